// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: scheduler state encoding and default FIFO geometry.
package cnn_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_ADDR_BIT = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;
endpackage

// File: rtl/fifo_access_sched_if.sv
// Producer/consumer side of the FIFO access scheduler; master drives requests, slave answers.
interface fifo_access_sched_if
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_WR  = 4
);
  logic [N_WR-1:0]       wr_req;
  logic [N_WR*WIDTH-1:0] wr_data;
  logic [N_WR-1:0]       wr_ack;
  logic                  rd_req;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [WIDTH-1:0]      rd_data;
  logic                  flush;
  logic                  flush_done;
  logic                  busy;

  modport master (
    output wr_req, wr_data, rd_req, flush,
    input  wr_ack, rd_ack, rd_valid, rd_data, flush_done, busy
  );

  modport slave (
    input  wr_req, wr_data, rd_req, flush,
    output wr_ack, rd_ack, rd_valid, rd_data, flush_done, busy
  );
endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO; 1-cycle registered read, ops gated by full/empty.
// A cycle with both wen and ren performs neither operation.
module fifo #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << ADDR_BIT;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_BIT-1:0] wptr;
  logic [ADDR_BIT-1:0] rptr;
  logic [ADDR_BIT:0]   count;
  logic                do_w;
  logic                do_r;

  assign empty = (count == '0);
  assign full  = (count == (ADDR_BIT+1)'(DEPTH));
  assign do_w  = wen & ~ren & ~full;
  assign do_r  = ren & ~wen & ~empty;

  always_ff @(posedge clk) begin
    if (do_w && !rst) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_w) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (do_r) begin
        dout  <= mem[rptr];
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_access_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
// Returns one-hot grant, its index, and whether any request is present.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  int j;

  // Walk downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = PW'(j);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_access_sched.sv
// Single-op-per-cycle FIFO scheduler: round-robin writers, one reader, drain-only flush mode.
// Grants are combinational, rd_valid one cycle after rd_ack; full/empty hold requests pending.
module fifo_access_sched
  import cnn_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_BIT = DEF_ADDR_BIT,
  parameter int N_WR     = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_access_sched_if.slave bus,
  output logic               fifo_wen,
  output logic               fifo_ren,
  output logic [WIDTH-1:0]   fifo_in,
  input  logic [WIDTH-1:0]   fifo_out,
  input  logic               fifo_empty,
  input  logic               fifo_full
);
  localparam int PW = $clog2(N_WR);

  if (N_WR < 2 || N_WR > 8 || ADDR_BIT < 1) begin : g_bad_param
    $error("fifo_access_sched: unsupported N_WR/ADDR_BIT");
  end

  sched_state_t  state;
  logic [PW-1:0] rr_ptr;
  logic          pref;
  logic          rd_valid_q;
  logic          flush_done_q;
  logic          busy_q;

  logic [N_WR-1:0] grant;
  logic [PW-1:0]   win;
  logic            any_req;
  logic            run;
  logic            rd_cand;
  logic            wr_cand;
  logic            do_wr;
  logic            do_rd;

  rr_arbiter #(.N(N_WR), .PW(PW)) u_arb (
    .req   (bus.wr_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (any_req)
  );

  assign run     = (state == RUN) & ~rst;
  assign rd_cand = run & bus.rd_req & ~fifo_empty;
  assign wr_cand = run & any_req & ~fifo_full;
  assign do_wr   = wr_cand & (~rd_cand | pref);
  assign do_rd   = rd_cand & ~do_wr;

  assign bus.wr_ack     = do_wr ? grant : '0;
  assign bus.rd_ack     = do_rd;
  assign fifo_wen       = do_wr;
  assign fifo_ren       = do_rd | (~rst & (state == FLUSH) & ~fifo_empty);
  assign fifo_in        = do_wr ? bus.wr_data[win*WIDTH +: WIDTH] : '0;
  assign bus.rd_data    = rst ? '0 : fifo_out;
  assign bus.rd_valid   = rd_valid_q & ~rst;
  assign bus.flush_done = flush_done_q & ~rst;
  assign bus.busy       = busy_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      rr_ptr       <= '0;
      pref         <= 1'b0;
      rd_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rd_valid_q   <= do_rd;
      flush_done_q <= 1'b0;
      if (rd_cand && wr_cand) pref <= ~pref;
      if (do_wr) rr_ptr <= (win == PW'(N_WR - 1)) ? '0 : win + 1'b1;
      case (state)
        RUN: begin
          if (bus.flush) begin
            state  <= FLUSH;
            busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          // Empty is sampled after the last drain read has landed.
          if (fifo_empty) begin
            state        <= RUN;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
